// File: rtl/fft_frame_streamer.sv
// Frame buffer/sequencer ahead of the FFT core: stores up to NUM_FRAMES frames and replays each as one burst.
// Define FFT_STREAMER_BITREV_EN to replay each frame in bit-reversed address order.
module fft_frame_streamer #(
    parameter int SIZE_BUFFER   = 8,
    parameter int DATA_FFT_SIZE = 16,
    parameter int NUM_FRAMES    = 2,
    parameter int GAP_W         = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_FFT_SIZE-1:0]        data_in_i,
    input  logic [DATA_FFT_SIZE-1:0]        data_in_q,
    input  logic [GAP_W-1:0]                gap_len,
    input  logic                            flag_wayt_data,
    output logic                            valid,
    output logic [DATA_FFT_SIZE-1:0]        data_out_i,
    output logic [DATA_FFT_SIZE-1:0]        data_out_q,
    output logic                            frame_start,
    output logic [$clog2(NUM_FRAMES+1)-1:0] frames_stored
);

    localparam int NFFT   = 1 << SIZE_BUFFER;
    localparam int SLOT_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int CNT_W  = $clog2(NUM_FRAMES + 1);
    localparam int ADDR_W = SLOT_W + SIZE_BUFFER;
    localparam int WORD_W = 2 * DATA_FFT_SIZE;
    localparam int DEPTH  = NUM_FRAMES * NFFT;

    localparam logic [CNT_W-1:0]       FULL_CNT  = CNT_W'(NUM_FRAMES);
    localparam logic [SLOT_W-1:0]      LAST_SLOT = SLOT_W'(NUM_FRAMES - 1);
    localparam logic [SIZE_BUFFER-1:0] LAST_OFF  = '1;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        GAP
    } state_t;

    logic [WORD_W-1:0]      mem [DEPTH];

    logic                   up;
    logic [SIZE_BUFFER-1:0] wr_off;
    logic [SLOT_W-1:0]      wr_slot;
    logic                   accept;
    logic                   commit;

    state_t                 state;
    logic [SIZE_BUFFER-1:0] rd_cnt;
    logic [SIZE_BUFFER-1:0] rd_off;
    logic [SLOT_W-1:0]      rd_slot;
    logic [ADDR_W-1:0]      rd_addr;
    logic [GAP_W-1:0]       gap_cnt;
    logic                   release_pend;

    // up keeps in_ready low while reset is held and for the release cycle
    assign in_ready = up && (frames_stored < FULL_CNT);
    assign accept   = in_valid && in_ready;
    assign commit   = accept && (wr_off == LAST_OFF);

`ifdef FFT_STREAMER_BITREV_EN
    always_comb begin
        rd_off = '0;
        for (int unsigned b = 0; b < SIZE_BUFFER; b++)
            rd_off[b] = rd_cnt[SIZE_BUFFER-1-b];
    end
`else
    assign rd_off = rd_cnt;
`endif

    assign rd_addr = {rd_slot, rd_off};

    always_ff @(posedge clk) begin
        if (accept)
            mem[{wr_slot, wr_off}] <= {data_in_i, data_in_q};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            up            <= 1'b0;
            wr_off        <= '0;
            wr_slot       <= '0;
            frames_stored <= '0;
        end else begin
            up <= 1'b1;
            if (accept) begin
                wr_off <= wr_off + 1'b1;
                if (commit)
                    wr_slot <= (wr_slot == LAST_SLOT) ? '0 : wr_slot + 1'b1;
            end
            if (commit && !release_pend)
                frames_stored <= frames_stored + 1'b1;
            else if (!commit && release_pend)
                frames_stored <= frames_stored - 1'b1;
        end
    end

    // The FSM runs one cycle ahead of valid because of the registered RAM read.
    // The slot is freed one cycle after the last read so in_ready returns as valid drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            rd_cnt       <= '0;
            rd_slot      <= '0;
            gap_cnt      <= '0;
            release_pend <= 1'b0;
            valid        <= 1'b0;
            frame_start  <= 1'b0;
            data_out_i   <= '0;
            data_out_q   <= '0;
        end else begin
            release_pend <= 1'b0;
            case (state)
                IDLE: begin
                    valid       <= 1'b0;
                    frame_start <= 1'b0;
                    if ((frames_stored != '0) && flag_wayt_data) begin
                        state  <= STREAM;
                        rd_cnt <= '0;
                    end
                end
                STREAM: begin
                    valid                    <= 1'b1;
                    frame_start              <= (rd_cnt == '0);
                    {data_out_i, data_out_q} <= mem[rd_addr];
                    rd_cnt                   <= rd_cnt + 1'b1;
                    if (rd_cnt == LAST_OFF) begin
                        state        <= GAP;
                        release_pend <= 1'b1;
                        rd_slot      <= (rd_slot == LAST_SLOT) ? '0 : rd_slot + 1'b1;
                        gap_cnt      <= (gap_len == '0) ? GAP_W'(1) : gap_len;
                    end
                end
                GAP: begin
                    valid       <= 1'b0;
                    frame_start <= 1'b0;
                    if (gap_cnt <= GAP_W'(1))
                        state <= IDLE;
                    else
                        gap_cnt <= gap_cnt - 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    valid       <= 1'b0;
                    frame_start <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_streamer.sv
// Self-checking bench for fft_frame_streamer: scoreboard of whole frames plus directed timing checks.
// Honours FFT_STREAMER_BITREV_EN for the expected replay order.
module tb_fft_frame_streamer;
    localparam int SB   = 8;
    localparam int W    = 16;
    localparam int NF   = 2;
    localparam int GW   = 8;
    localparam int NFFT = 1 << SB;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  data_in_i = '0;
    logic [W-1:0]  data_in_q = '0;
    logic [GW-1:0] gap_len = '0;
    logic          flag_wayt_data = 1'b0;
    logic          valid;
    logic [W-1:0]  data_out_i;
    logic [W-1:0]  data_out_q;
    logic          frame_start;
    logic [1:0]    frames_stored;

    fft_frame_streamer #(
        .SIZE_BUFFER(SB),
        .DATA_FFT_SIZE(W),
        .NUM_FRAMES(NF),
        .GAP_W(GW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .data_in_i(data_in_i),
        .data_in_q(data_in_q),
        .gap_len(gap_len),
        .flag_wayt_data(flag_wayt_data),
        .valid(valid),
        .data_out_i(data_out_i),
        .data_out_q(data_out_q),
        .frame_start(frame_start),
        .frames_stored(frames_stored)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [31:0] exp_q[$];
    logic [31:0] wr_buf [NFFT];
    int          wr_n = 0;

    bit          in_burst = 1'b0;
    bit          seen_burst = 1'b0;
    int          pos = 0;
    int          bursts = 0;
    int          low_run = 0;
    int          last_low = 0;
    int          first_valid_cyc = -100;
    int          end_cyc = -100;
    logic [W-1:0] last_i = '0;
    logic [W-1:0] last_q = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output position p carries input sample out_order(p) of the same frame.
    function automatic int out_order(input int p);
`ifdef FFT_STREAMER_BITREV_EN
        int r;
        r = 0;
        for (int b = 0; b < SB; b++)
            r = r * 2 + ((p >> b) & 1);
        return r;
`else
        return p;
`endif
    endfunction

    function automatic logic [31:0] mk(input bit ramp);
        if (ramp)
            return {W'(wr_n), W'(NFFT - 1 - wr_n)};
        return $urandom();
    endfunction

    task automatic drive(input logic [31:0] w);
        data_in_i = w[31:16];
        data_in_q = w[15:0];
    endtask

    task automatic on_accept(input logic [31:0] w);
        wr_buf[wr_n] = w;
        wr_n++;
        if (wr_n == NFFT) begin
            for (int p = 0; p < NFFT; p++)
                exp_q.push_back(wr_buf[out_order(p)]);
            wr_n = 0;
        end
    endtask

    // One clock: report whether the sample on the inputs was taken, then observe outputs.
    task automatic step(output bit acc);
        logic [31:0] e;
        acc = (in_valid === 1'b1) && (in_ready === 1'b1) && (reset === 1'b1);
        @(posedge clk);
        #1;
        cyc++;
        if (reset !== 1'b1) begin
            in_burst = 1'b0;
            pos      = 0;
            last_i   = '0;
            last_q   = '0;
        end else if (valid === 1'b1) begin
            if (!in_burst) begin
                in_burst        = 1'b1;
                pos             = 0;
                first_valid_cyc = cyc;
                if (seen_burst)
                    last_low = low_run;
            end
            check("frame_start", frame_start, pos == 0);
            if (exp_q.size() == 0)
                check("spurious_valid", valid, 0);
            else begin
                e = exp_q.pop_front();
                check("data_i", data_out_i, e[31:16]);
                check("data_q", data_out_q, e[15:0]);
            end
            pos++;
            last_i = data_out_i;
            last_q = data_out_q;
        end else begin
            if (in_burst) begin
                check("burst_len", pos, NFFT);
                in_burst   = 1'b0;
                seen_burst = 1'b1;
                bursts++;
                low_run = 0;
                end_cyc = cyc;
            end
            low_run++;
            check("frame_start_idle", frame_start, 0);
            check("hold_i", data_out_i, last_i);
            check("hold_q", data_out_q, last_q);
        end
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++)
            step(a);
    endtask

    task automatic push_frames(input int n, input bit ramp, output int last_acc);
        bit          a;
        int          sent;
        int          budget;
        int          last_c;
        logic [31:0] w;
        sent     = 0;
        budget   = n * 4 + 2000;
        last_acc = -100;
        w        = mk(ramp);
        drive(w);
        in_valid = 1'b1;
        while (sent < n && budget > 0) begin
            last_c = cyc;
            step(a);
            budget--;
            if (a) begin
                on_accept(w);
                sent++;
                last_acc = last_c;
                w = mk(ramp);
                drive(w);
            end
        end
        in_valid = 1'b0;
        check("push_done", sent, n);
    endtask

    task automatic drain(input int limit);
        bit a;
        int c;
        c = 0;
        while ((exp_q.size() != 0 || valid === 1'b1) && c < limit) begin
            step(a);
            c++;
        end
        check("drain_queue", exp_q.size(), 0);
        check("drain_valid", valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          a;
        int          last_acc;
        int          b0;
        int          sent;
        int          stall;
        int          raise_cyc;
        int          guard;
        bit          prev_rdy;
        bit          rdy_checked;
        logic [31:0] w;

        // Reset values
        #12;
        check("rst_valid", valid, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_data_i", data_out_i, 0);
        check("rst_data_q", data_out_q, 0);
        check("rst_frames_stored", frames_stored, 0);
        check("rst_in_ready", in_ready, 0);
        idle(2);
        reset = 1'b1;
        step(a);
        check("ready_after_release", in_ready, 1);
        check("stored_after_release", frames_stored, 0);

        // Single ramp frame, gap 30
        gap_len = 30;
        flag_wayt_data = 1'b1;
        b0 = bursts;
        push_frames(NFFT, 1'b1, last_acc);
        drain(1000);
        check("start_latency", first_valid_cyc - last_acc, 3);
        check("single_bursts", bursts - b0, 1);
        check("single_stored", frames_stored, 0);
        idle(30);
        check("single_gap_low", low_run, 31);

        // Fill to full with gating low, stall, then release with gap 0
        flag_wayt_data = 1'b0;
        gap_len = 0;
        sent = 0;
        stall = 0;
        w = mk(1'b0);
        drive(w);
        in_valid = 1'b1;
        for (int c = 0; c < 800 && stall < 20; c++) begin
            step(a);
            if (a) begin
                on_accept(w);
                sent++;
                w = mk(1'b0);
                drive(w);
                if (sent == NFFT)
                    check("stored_one", frames_stored, 1);
                if (sent == 2 * NFFT) begin
                    check("full_stored", frames_stored, 2);
                    check("full_ready_low", in_ready, 0);
                end
            end
            if (sent >= 2 * NFFT)
                stall++;
        end
        check("stall_accepts", sent, 2 * NFFT);
        check("full_no_valid", valid, 0);

        flag_wayt_data = 1'b1;
        b0 = bursts;
        prev_rdy = (in_ready === 1'b1);
        rdy_checked = 1'b0;
        for (int c = 0; c < 1500 && sent < 600; c++) begin
            step(a);
            if (a) begin
                on_accept(w);
                sent++;
                w = mk(1'b0);
                drive(w);
            end
            if (!rdy_checked && in_ready === 1'b1 && !prev_rdy) begin
                check("ready_return_cycle", cyc, end_cyc);
                check("ready_return_bursts", bursts - b0, 1);
                rdy_checked = 1'b1;
            end
            prev_rdy = (in_ready === 1'b1);
        end
        in_valid = 1'b0;
        check("ready_returned", rdy_checked, 1);
        check("sent_600", sent, 600);
        check("b2b_low_gap0", last_low, 2);
        push_frames(3 * NFFT - 600, 1'b0, last_acc);
        drain(2000);
        check("full_bursts", bursts - b0, 3);
        check("full_drained_stored", frames_stored, 0);

        // Two stored frames with gap 5
        flag_wayt_data = 1'b0;
        gap_len = 5;
        push_frames(2 * NFFT, 1'b0, last_acc);
        check("two_stored", frames_stored, 2);
        b0 = bursts;
        flag_wayt_data = 1'b1;
        drain(2000);
        check("gap5_bursts", bursts - b0, 2);
        check("gap5_low", last_low, 6);

        // Gating: hold off, start, drop mid-burst
        flag_wayt_data = 1'b0;
        gap_len = 3;
        push_frames(NFFT, 1'b0, last_acc);
        b0 = bursts;
        idle(50);
        check("gated_no_burst", bursts - b0, 0);
        check("gated_valid", valid, 0);
        flag_wayt_data = 1'b1;
        raise_cyc = cyc;
        guard = 0;
        while (valid !== 1'b1 && guard < 20) begin
            step(a);
            guard++;
        end
        check("gate_start_latency", first_valid_cyc - raise_cyc, 2);
        guard = 0;
        while (pos < 10 && guard < 50) begin
            step(a);
            guard++;
        end
        flag_wayt_data = 1'b0;
        drain(1000);
        check("gated_full_burst", bursts - b0, 1);

        // Reset in the middle of a burst with a second frame buffered
        gap_len = 2;
        push_frames(2 * NFFT, 1'b0, last_acc);
        check("pre_reset_stored", frames_stored, 2);
        b0 = bursts;
        flag_wayt_data = 1'b1;
        guard = 0;
        while ((!in_burst || pos < 100) && guard < 400) begin
            step(a);
            guard++;
        end
        check("reached_sample_100", pos, 100);
        reset = 1'b0;
        #1;
        check("midrst_valid", valid, 0);
        check("midrst_frame_start", frame_start, 0);
        check("midrst_data_i", data_out_i, 0);
        check("midrst_data_q", data_out_q, 0);
        check("midrst_frames_stored", frames_stored, 0);
        check("midrst_in_ready", in_ready, 0);
        exp_q.delete();
        wr_n = 0;
        for (int i = 0; i < 3; i++) begin
            step(a);
            check("ready_during_reset", in_ready, 0);
        end
        reset = 1'b1;
        step(a);
        check("ready_after_midrst", in_ready, 1);
        check("stored_after_midrst", frames_stored, 0);
        idle(20);
        check("discarded_frames", bursts - b0, 0);

        // Normal operation after reset
        gap_len = 4;
        b0 = bursts;
        push_frames(NFFT, 1'b0, last_acc);
        drain(1000);
        check("post_reset_burst", bursts - b0, 1);
        check("post_reset_stored", frames_stored, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
